// File: rtl/mux_l1_arbitro.sv
// Receive end of the recirculator's active path: four lane FIFOs merged by a
// round-robin arbiter onto one registered valid/ready output stream.
module mux_l1_arbitro #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  valid_in0,
  input  logic                  valid_in1,
  input  logic                  valid_in2,
  input  logic                  valid_in3,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            lane_out,
  output logic                  pause0,
  output logic                  pause1,
  output logic                  pause2,
  output logic                  pause3,
  output logic [3:0]            overflow_err
);

  localparam int LANES = 4;

  logic [DATA_WIDTH-1:0] mem [LANES][FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr [LANES];
  logic [PTR_WIDTH-1:0]  rd_ptr [LANES];
  logic [PTR_WIDTH:0]    count  [LANES];

  logic [DATA_WIDTH-1:0] lane_data [LANES];
  logic [LANES-1:0]      lane_valid;
  logic [LANES-1:0]      nonempty;
  logic [LANES-1:0]      full;
  logic [LANES-1:0]      pop;
  logic [LANES-1:0]      push;
  logic [LANES-1:0]      pause_vec;

  logic [1:0]            rr_ptr;
  logic [1:0]            sel;
  logic [1:0]            idx;
  logic                  grant;
  logic                  load;
  logic [DATA_WIDTH-1:0] head_data;

  assign lane_data[0] = data_in0;
  assign lane_data[1] = data_in1;
  assign lane_data[2] = data_in2;
  assign lane_data[3] = data_in3;
  assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};

  // Handshake: a word on data_out transfers on any posedge where
  // valid_out=1 and ready_out=1. The output register may reload whenever it
  // is empty or being drained; otherwise it holds data, lane and valid.
  assign load = !valid_out || ready_out;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      nonempty[i]  = (count[i] != '0);
      full[i]      = (count[i] == (PTR_WIDTH+1)'(FIFO_DEPTH));
      pause_vec[i] = (count[i] >= (PTR_WIDTH+1)'(FIFO_DEPTH - 1));
    end
  end

  // Scan starts at rr_ptr; first non-empty lane (pre-write counts) wins.
  always_comb begin
    grant = 1'b0;
    sel   = rr_ptr;
    idx   = rr_ptr;
    for (int k = 0; k < LANES; k++) begin
      idx = rr_ptr + 2'(k);
      if (!grant && nonempty[idx]) begin
        grant = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && grant) begin
      pop[sel] = 1'b1;
    end
  end

  // A full FIFO still accepts a word when it is popped in the same cycle.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      push[i] = lane_valid[i] && (!full[i] || pop[i]);
    end
  end

  assign head_data = mem[sel][rd_ptr[sel]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= lane_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      overflow_err <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_WIDTH'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_WIDTH'(1);
        end
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + (PTR_WIDTH+1)'(1);
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - (PTR_WIDTH+1)'(1);
        end
        if (lane_valid[i] && !push[i]) begin
          overflow_err[i] <= 1'b1;
        end
      end
    end
  end

  // When nothing is granted the old data/lane stay visible with valid low.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      lane_out  <= '0;
      valid_out <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (grant) begin
        data_out  <= head_data;
        lane_out  <= sel;
        valid_out <= 1'b1;
        rr_ptr    <= sel + 2'd1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

  assign pause0 = pause_vec[0];
  assign pause1 = pause_vec[1];
  assign pause2 = pause_vec[2];
  assign pause3 = pause_vec[3];

endmodule

// File: tb/tb_mux_l1_arbitro.sv
// Directed bench for mux_l1_arbitro: one task per scenario, inline checks,
// single summary line at the end.
module tb_mux_l1_arbitro;

  logic       clk;
  logic       reset;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic       valid_in0, valid_in1, valid_in2, valid_in3;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic       pause0, pause1, pause2, pause3;
  logic [3:0] overflow_err;
  logic [3:0] pause_v;

  int checks;
  int failures;

  assign pause_v = {pause3, pause2, pause1, pause0};

  mux_l1_arbitro dut (
    .clk          (clk),
    .reset        (reset),
    .data_in0     (data_in0),
    .data_in1     (data_in1),
    .data_in2     (data_in2),
    .data_in3     (data_in3),
    .valid_in0    (valid_in0),
    .valid_in1    (valid_in1),
    .valid_in2    (valid_in2),
    .valid_in3    (valid_in3),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .lane_out     (lane_out),
    .pause0       (pause0),
    .pause1       (pause1),
    .pause2       (pause2),
    .pause3       (pause3),
    .overflow_err (overflow_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    valid_in0 = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0; valid_in3 = 1'b0;
    data_in0 = 8'h00; data_in1 = 8'h00; data_in2 = 8'h00; data_in3 = 8'h00;
  endtask

  task automatic do_reset();
    idle_lanes();
    ready_out = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid_out !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b exp=0", valid_out);
    end
    checks++;
    if (data_out !== 8'h00 || lane_out !== 2'd0) begin
      failures++; $display("FAIL reset_data got=%h/%0d exp=00/0", data_out, lane_out);
    end
    checks++;
    if (pause_v !== 4'b0000 || overflow_err !== 4'b0000) begin
      failures++; $display("FAIL reset_flags pause=%b ovf=%b exp=0000/0000", pause_v, overflow_err);
    end
  endtask

  task automatic test_all_lanes();
    logic [7:0] exp_d [4];
    exp_d = '{8'h00, 8'h0E, 8'h0E, 8'h4E};
    do_reset();
    valid_in0 = 1'b1; valid_in1 = 1'b1; valid_in2 = 1'b1; valid_in3 = 1'b1;
    data_in0 = 8'h00; data_in1 = 8'h0E; data_in2 = 8'h0E; data_in3 = 8'h4E;
    tick();
    idle_lanes();
    checks++;
    if (valid_out !== 1'b0) begin
      failures++; $display("FAIL all_lanes_latency valid got=%0b exp=0", valid_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp_d[i] || lane_out !== 2'(i)) begin
        failures++;
        $display("FAIL all_lanes_word%0d got=%0b/%h/%0d exp=1/%h/%0d",
                 i, valid_out, data_out, lane_out, exp_d[i], i);
      end
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      failures++; $display("FAIL all_lanes_drain valid got=%0b exp=0", valid_out);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ready_out = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      valid_in2 = 1'b1;
      data_in2  = 8'(i);
      tick();
    end
    idle_lanes();
    checks++;
    if (overflow_err !== 4'b0100) begin
      failures++; $display("FAIL overflow_flag got=%b exp=0100", overflow_err);
    end
    checks++;
    if (pause_v !== 4'b0100) begin
      failures++; $display("FAIL overflow_pause got=%b exp=0100", pause_v);
    end
    ready_out = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (valid_out !== 1'b1 || data_out !== 8'(i) || lane_out !== 2'd2) begin
        failures++;
        $display("FAIL overflow_drain%0d got=%0b/%h/%0d exp=1/%h/2",
                 i, valid_out, data_out, lane_out, 8'(i));
      end
      tick();
    end
    checks++;
    if (valid_out !== 1'b0 || overflow_err !== 4'b0100 || pause_v !== 4'b0000) begin
      failures++;
      $display("FAIL overflow_end valid=%0b ovf=%b pause=%b exp=0/0100/0000",
               valid_out, overflow_err, pause_v);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp_data;
    logic [1:0] exp_lane;
    do_reset();
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 6) begin
        valid_in0 = 1'b1; data_in0 = 8'hA0 + 8'(cyc);
        valid_in3 = 1'b1; data_in3 = 8'hD0 + 8'(cyc);
      end else begin
        idle_lanes();
      end
      tick();
      if (cyc >= 1 && cyc <= 12) begin
        exp_lane = ((cyc - 1) % 2 == 0) ? 2'd0 : 2'd3;
        exp_data = (exp_lane == 2'd0 ? 8'hA0 : 8'hD0) + 8'((cyc - 1) / 2);
        checks++;
        if (valid_out !== 1'b1 || data_out !== exp_data || lane_out !== exp_lane) begin
          failures++;
          $display("FAIL alternate_word%0d got=%0b/%h/%0d exp=1/%h/%0d",
                   cyc - 1, valid_out, data_out, lane_out, exp_data, exp_lane);
        end
      end
    end
    checks++;
    if (valid_out !== 1'b0 || overflow_err !== 4'b0000) begin
      failures++;
      $display("FAIL alternate_end valid=%0b ovf=%b exp=0/0000", valid_out, overflow_err);
    end
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    valid_in1 = 1'b1; data_in1 = 8'hC0;
    tick();
    data_in1 = 8'hC1;
    tick();
    idle_lanes();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hC0 || lane_out !== 2'd1) begin
      failures++; $display("FAIL stall_first got=%0b/%h/%0d exp=1/c0/1", valid_out, data_out, lane_out);
    end
    ready_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (valid_out !== 1'b1 || data_out !== 8'hC0 || lane_out !== 2'd1) begin
        failures++;
        $display("FAIL stall_hold%0d got=%0b/%h/%0d exp=1/c0/1", i, valid_out, data_out, lane_out);
      end
    end
    ready_out = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hC1 || lane_out !== 2'd1) begin
      failures++; $display("FAIL stall_next got=%0b/%h/%0d exp=1/c1/1", valid_out, data_out, lane_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'hC1) begin
      failures++; $display("FAIL stall_empty got=%0b/%h exp=0/c1", valid_out, data_out);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    ready_out = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc < 3) begin
        valid_in0 = 1'b1; data_in0 = 8'h10 + 8'(cyc);
        valid_in1 = 1'b1; data_in1 = 8'h20 + 8'(cyc);
        valid_in2 = 1'b1; data_in2 = 8'h30 + 8'(cyc);
      end else begin
        valid_in0 = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0;
      end
      valid_in3 = 1'b1; data_in3 = 8'h40 + 8'(cyc);
      tick();
    end
    idle_lanes();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h10 || pause_v !== 4'b1110 || overflow_err !== 4'b1000) begin
      failures++;
      $display("FAIL midflight_pre got=%0b/%h/%b/%b exp=1/10/1110/1000",
               valid_out, data_out, pause_v, overflow_err);
    end
    reset = 1'b1;
    ready_out = 1'b1;
    valid_in1 = 1'b1; data_in1 = 8'h55;
    tick();
    reset = 1'b0;
    idle_lanes();
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || lane_out !== 2'd0) begin
      failures++;
      $display("FAIL midflight_reset_out got=%0b/%h/%0d exp=0/00/0", valid_out, data_out, lane_out);
    end
    checks++;
    if (pause_v !== 4'b0000 || overflow_err !== 4'b0000) begin
      failures++;
      $display("FAIL midflight_reset_flags pause=%b ovf=%b exp=0000/0000", pause_v, overflow_err);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      failures++; $display("FAIL midflight_no_stale valid got=%0b exp=0", valid_out);
    end
    valid_in1 = 1'b1; data_in1 = 8'h8E;
    tick();
    idle_lanes();
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h8E || lane_out !== 2'd1) begin
      failures++;
      $display("FAIL midflight_new_word got=%0b/%h/%0d exp=1/8e/1", valid_out, data_out, lane_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      failures++; $display("FAIL midflight_drain valid got=%0b exp=0", valid_out);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_lanes();
    ready_out = 1'b1;
    reset = 1'b1;
    tick();
    test_reset();
    test_all_lanes();
    test_overflow();
    test_alternate();
    test_back_to_back_stall();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
